// File: rtl/motion_stream_sequencer.sv
// Frame sequencer that pops three FWFT pixel FIFOs in lockstep into a one-entry output stage.
// Optional stall watchdog (timeout port) is built when MOTION_SEQ_TIMEOUT_EN is defined.
module motion_stream_sequencer #(
  parameter int IMG_WIDTH      = 768,
  parameter int IMG_HEIGHT     = 576,
  parameter int DATA_WIDTH     = 24,
  parameter int CNT_WIDTH      = 19,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  pixel_count,
`ifdef MOTION_SEQ_TIMEOUT_EN
  output logic                  timeout,
`endif
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  in_rd_en,
  input  logic                  hold_empty,
  input  logic [DATA_WIDTH-1:0] hold_dout,
  output logic                  hold_rd_en,
  input  logic                  base_empty,
  input  logic [DATA_WIDTH-1:0] base_dout,
  output logic                  base_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_frame,
  output logic [DATA_WIDTH-1:0] out_hold,
  output logic [DATA_WIDTH-1:0] out_base
);

  localparam logic [CNT_WIDTH-1:0] LAST_PIX = CNT_WIDTH'(IMG_WIDTH*IMG_HEIGHT-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic o_valid, busy_st, write_ok, fire_raw, fire, kill;

  assign busy_st  = (state == RUN) || (state == DRAIN);
  assign write_ok = o_valid && !out_full;
  assign fire_raw = (state == RUN) && !in_empty && !hold_empty && !base_empty
                    && (!o_valid || !out_full);

`ifdef MOTION_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] stall_cnt;
  logic          stall;

  assign stall   = busy_st && !fire_raw && !write_ok;
  assign timeout = stall && (stall_cnt == TW'(TIMEOUT_CYCLES-1));
  assign kill    = busy_st && (abort || timeout);

  always_ff @(posedge clock or negedge reset)
    if (!reset)          stall_cnt <= '0;
    else if (stall && !kill) stall_cnt <= stall_cnt + TW'(1);
    else                 stall_cnt <= '0;
`else
  assign kill = busy_st && abort;
`endif

  // A killed frame neither consumes another triple nor writes the pending one.
  assign fire       = fire_raw && !kill;
  assign in_rd_en   = fire;
  assign hold_rd_en = fire;
  assign base_rd_en = fire;
  assign out_wr_en  = write_ok && !kill;
  assign busy       = busy_st;
  assign frame_done = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      o_valid     <= 1'b0;
      pixel_count <= '0;
      out_frame   <= '0;
      out_hold    <= '0;
      out_base    <= '0;
    end else if (kill) begin
      state       <= IDLE;
      o_valid     <= 1'b0;
      pixel_count <= '0;
    end else begin
      if (fire) begin
        out_frame   <= in_dout;
        out_hold    <= hold_dout;
        out_base    <= base_dout;
        o_valid     <= 1'b1;
        pixel_count <= pixel_count + CNT_WIDTH'(1);
      end else if (out_wr_en) begin
        o_valid <= 1'b0;
      end
      case (state)
        IDLE:  if (start && !abort) begin
                 state       <= RUN;
                 pixel_count <= '0;
               end
        RUN:   if (fire && pixel_count == LAST_PIX) state <= DRAIN;
        DRAIN: if (!o_valid || !out_full) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_stream_sequencer.sv
// Directed bench for motion_stream_sequencer on a 4x2 frame with counting FIFO models.
module tb_motion_stream_sequencer;
  localparam int DW = 24;
  localparam int CW = 19;

  logic clock = 0, reset = 0, start = 0, abort = 0;
  logic busy, frame_done;
  logic [CW-1:0] pixel_count;
  logic in_empty = 0, hold_empty = 0, base_empty = 0, out_full = 0;
  logic in_rd_en, hold_rd_en, base_rd_en, out_wr_en;
  logic [DW-1:0] in_dout, hold_dout, base_dout, out_frame, out_hold, out_base;
`ifdef MOTION_SEQ_TIMEOUT_EN
  logic timeout;
`endif

  logic [15:0] in_idx = 0, hold_idx = 0, base_idx = 0;
  logic [15:0] exp_idx;
  int vec_cnt = 0, err_cnt = 0;

  always #5 clock = ~clock;

  // FWFT FIFO models: each pop advances that stream's own pixel index.
  assign in_dout   = {8'hA1, in_idx};
  assign hold_dout = {8'hB2, hold_idx};
  assign base_dout = {8'hC3, base_idx};
  always @(posedge clock) begin
    if (in_rd_en)   in_idx   <= in_idx + 16'd1;
    if (hold_rd_en) hold_idx <= hold_idx + 16'd1;
    if (base_rd_en) base_idx <= base_idx + 16'd1;
  end

  motion_stream_sequencer #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count),
`ifdef MOTION_SEQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .hold_empty(hold_empty), .hold_dout(hold_dout), .hold_rd_en(hold_rd_en),
    .base_empty(base_empty), .base_dout(base_dout), .base_rd_en(base_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en),
    .out_frame(out_frame), .out_hold(out_hold), .out_base(out_base)
  );

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #1;
    vec_cnt++;
    if ({busy, frame_done, out_wr_en, in_rd_en, hold_rd_en, base_rd_en} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, frame_done, out_wr_en, in_rd_en, hold_rd_en, base_rd_en});
    end
    vec_cnt++;
    if (pixel_count !== '0 || {out_frame, out_hold, out_base} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: count %0d frame %h hold %h base %h want all 0",
               pixel_count, out_frame, out_hold, out_base);
    end
    tick(); reset = 1; tick();
  endtask

  // mode 0: clean frame, 1: base FIFO empty 5 cycles, 2: out_full 3 cycles, 3: extra start mid-run
  task automatic run_frame(input int mode);
    int writes = 0, dones = 0;
    logic stall_b, stall_o;
    exp_idx = in_idx;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 40; k++) begin
      stall_b = (mode == 1) && k >= 3 && k <= 7;
      stall_o = (mode == 2) && k >= 4 && k <= 6;
      base_empty = stall_b;
      out_full   = stall_o;
      start      = (mode == 3) && k == 3;
      #1;
      vec_cnt++;
      if (in_rd_en !== hold_rd_en || in_rd_en !== base_rd_en) begin
        err_cnt++;
        $display("FAIL lockstep k=%0d: rd_en in/hold/base %b%b%b want equal",
                 k, in_rd_en, hold_rd_en, base_rd_en);
      end
      if (stall_b || stall_o) begin
        vec_cnt++;
        if (in_rd_en !== 1'b0 || (stall_o && out_wr_en !== 1'b0)) begin
          err_cnt++;
          $display("FAIL stall_hold k=%0d: rd_en %b wr_en %b want 0", k, in_rd_en, out_wr_en);
        end
      end
      if (mode == 0 || mode == 3) begin
        vec_cnt++;
        if (in_rd_en !== (k <= 8) || out_wr_en !== (k >= 2 && k <= 9)
            || frame_done !== (k == 10) || busy !== (k <= 9)) begin
          err_cnt++;
          $display("FAIL timing k=%0d: rd %b wr %b done %b busy %b want %b %b %b %b",
                   k, in_rd_en, out_wr_en, frame_done, busy,
                   k <= 8, k >= 2 && k <= 9, k == 10, k <= 9);
        end
      end
      if (out_wr_en === 1'b1) begin
        vec_cnt++;
        if (out_frame !== {8'hA1, exp_idx} || out_hold !== {8'hB2, exp_idx}
            || out_base !== {8'hC3, exp_idx}) begin
          err_cnt++;
          $display("FAIL out_triple k=%0d: got %h %h %h want index %0d",
                   k, out_frame, out_hold, out_base, exp_idx);
        end
        exp_idx++;
        writes++;
      end
      if (frame_done === 1'b1) begin
        dones++;
        vec_cnt++;
        if (pixel_count !== CW'(8)) begin
          err_cnt++;
          $display("FAIL done_count: got %0d want 8", pixel_count);
        end
        break;
      end
      tick();
    end
    start = 0; base_empty = 0; out_full = 0;
    vec_cnt++;
    if (writes != 8 || dones != 1) begin
      err_cnt++;
      $display("FAIL frame_totals mode=%0d: writes %0d dones %0d want 8 1", mode, writes, dones);
    end
    tick();
    vec_cnt++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL back_to_idle: busy %b done %b want 0 0", busy, frame_done);
    end
  endtask

  task automatic test_full_frame();   run_frame(0); endtask
  task automatic test_base_stall();   run_frame(1); endtask
  task automatic test_out_full();     run_frame(2); endtask
  task automatic test_start_in_run(); run_frame(3); endtask

  task automatic test_abort();
    exp_idx = in_idx;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (k >= 2) begin
        vec_cnt++;
        if (out_wr_en !== 1'b1 || out_frame !== {8'hA1, exp_idx}) begin
          err_cnt++;
          $display("FAIL abort_pre k=%0d: wr %b frame %h want 1 index %0d",
                   k, out_wr_en, out_frame, exp_idx);
        end
        exp_idx++;
      end
      tick();
    end
    abort = 1; #1;
    vec_cnt++;
    if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_cycle: wr %b rd %b want 0 0", out_wr_en, in_rd_en);
    end
    tick(); abort = 0; #1;
    vec_cnt++;
    if (busy !== 1'b0 || pixel_count !== '0 || frame_done !== 1'b0 || out_wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_after: busy %b count %0d done %b wr %b want 0 0 0 0",
               busy, pixel_count, frame_done, out_wr_en);
    end
    tick();
    vec_cnt++;
    if (frame_done !== 1'b0 || out_wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_quiet: done %b wr %b want 0 0", frame_done, out_wr_en);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    for (int k = 0; k < 2; k++) begin
      vec_cnt++;
      if (busy !== 1'b0 || in_rd_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL start_abort_idle: busy %b rd %b want 0 0", busy, in_rd_en);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    reset = 0; #1;
    vec_cnt++;
    if ({busy, frame_done, out_wr_en, in_rd_en, hold_rd_en, base_rd_en} !== 6'b0
        || pixel_count !== '0 || {out_frame, out_hold, out_base} !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid: ctrl %b count %0d frame %h want 0",
               {busy, frame_done, out_wr_en, in_rd_en, hold_rd_en, base_rd_en},
               pixel_count, out_frame);
    end
    tick(); reset = 1; tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_base_stall();
    test_out_full();
    test_abort();
    test_full_frame();
    test_start_in_run();
    test_start_abort_idle();
    test_reset_mid();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/motion_stream_sequencer.md
Name: motion_stream_sequencer

Overview:
- Frame-level controller in front of motion_detect_top.
- Pops the three FWFT pixel FIFOs (current frame, hold copy of current frame, base frame) strictly in lockstep, so pixel N of every stream is consumed in the same cycle.
- Forwards each aligned triple through a one-entry output stage into the downstream write port.
- Counts pixels per frame and sequences start, drain and done, so the datapath never sees misaligned or cross-frame pixels.

Parameters:
- IMG_WIDTH, 768, pixels per line
- IMG_HEIGHT, 576, lines per frame
- DATA_WIDTH, 24, bits per pixel (BGR packed)
- CNT_WIDTH, 19, pixel counter width; must satisfy 2**CNT_WIDTH > IMG_WIDTH*IMG_HEIGHT
- TIMEOUT_CYCLES, 4096, stall limit (optional feature only)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  single-cycle frame start request
- abort  in  1  synchronous frame abort
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse after last pixel written downstream
- pixel_count  out  CNT_WIDTH  pixels consumed in current frame
- in_empty  in  1  current-frame FIFO empty
- in_dout  in  DATA_WIDTH  current-frame FWFT data
- in_rd_en  out  1  current-frame pop
- hold_empty  in  1  hold FIFO empty
- hold_dout  in  DATA_WIDTH  hold FWFT data
- hold_rd_en  out  1  hold pop
- base_empty  in  1  base FIFO empty
- base_dout  in  DATA_WIDTH  base FWFT data
- base_rd_en  out  1  base pop
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  downstream write strobe
- out_frame, out_hold, out_base  out  DATA_WIDTH each  aligned pixel triple

Behaviour:
- Reset: reset low clears asynchronously.
  - state=IDLE.
  - busy, frame_done, out_wr_en, in_rd_en, hold_rd_en, base_rd_en = 0.
  - pixel_count=0; out_frame/out_hold/out_base = 0; internal o_valid=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN, pixel_count<=0. Otherwise stay.
  - RUN, popping:
    - fire = !in_empty && !hold_empty && !base_empty && (!o_valid || !out_full).
    - fire drives all three rd_en high together, combinationally, in the same cycle. The rd_en strobes are never individually asserted.
    - On fire: the output registers load the three dout values, o_valid<=1, pixel_count<=pixel_count+1.
  - RUN -> DRAIN: on the fire where pixel_count == IMG_WIDTH*IMG_HEIGHT-1.
  - DRAIN: no pops. -> DONE when o_valid=0, or when o_valid=1 and out_full=0 (the final write retires this cycle).
  - DONE: frame_done=1 for exactly one cycle, pixel_count held at the frame total. -> IDLE next cycle.
- Output stage:
  - out_wr_en = o_valid && !out_full (combinational).
  - o_valid clears when written and not reloaded the same cycle.
  - Simultaneous write and fire keeps o_valid=1 with the new data. Throughput is 1 pixel/clock.
- Latency: a pixel popped in cycle T appears on out_* in T+1. out_wr_en asserts in T+1 if out_full=0.
- start while busy or in DONE: ignored.
- abort:
  - In RUN/DRAIN -> IDLE next edge; o_valid<=0, so a pending triple is discarded and not written; no frame_done; pixel_count<=0.
  - In IDLE/DONE: no effect.
  - abort and start in the same IDLE cycle: abort wins, stay IDLE.
- Partial availability: any FIFO empty means no pop from any FIFO. There is no partial consumption, and no requirement on relative fill levels.
- Asserting reset mid-frame has the same effect as reset; upstream FIFOs are not flushed by this block.
- busy = (state==RUN) || (state==DRAIN).

Optional Feature:
- Macro MOTION_SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter increments in RUN/DRAIN on every cycle with no fire and no out write; it resets to 0 on any fire or write.
  - At TIMEOUT_CYCLES the block behaves as abort and pulses extra output port timeout (1 bit) for one cycle.
- Undefined: no counter and no timeout port; the block stalls indefinitely.

Test Plan:
- Reset, start, all FIFOs always non-empty, out_full=0, with IMG_WIDTH=4, IMG_HEIGHT=2 -> 8 consecutive fires, out_wr_en high cycles 2..9 after start, frame_done one pulse, pixel_count=8 at DONE.
- base_empty held 1 for 5 cycles mid-frame -> in_rd_en, hold_rd_en, base_rd_en all 0 those cycles; output triples stay matched (in=hold=base index).
- out_full=1 for 3 cycles with o_valid=1 -> exactly one triple held, zero pops, no loss or duplication after release.
- abort in RUN after 3 pixels with a pending triple -> IDLE next cycle, pending triple not written, pixel_count=0, no frame_done; a new start runs a full 8-pixel frame.
- start pulsed during RUN and start+abort together in IDLE -> both ignored; reset asserted mid-frame -> all outputs 0 immediately.
- With MOTION_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, in_empty stuck 1 -> timeout pulse at stall cycle 16, state IDLE.
